// File: rtl/yas_router_pkg.sv
// yas_router_pkg
// Shared definitions for the yas_router_core datapath:
//   - FSM state encoding (2-bit)
//   - header field slice helpers (len/dest split and remaining-count width)
//   - config address of the crc_en register
// Optional feature macro used by the core: YAS_ROUTER_BCAST_EN.
package yas_router_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_FWD_ENC  = 2'd1;
  localparam logic [1:0] ST_CHK_ENC  = 2'd2;
  localparam logic [1:0] ST_DROP_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_FWD  = ST_FWD_ENC,
    S_CHK  = ST_CHK_ENC,
    S_DROP = ST_DROP_ENC
  } state_e;

  // Header = {len, dest}; dest occupies the low addr_w bits.
  function automatic int hdr_len_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int hdr_len_width(input int data_w, input int addr_w);
    return data_w - addr_w;
  endfunction

  // One extra bit so that len all-ones plus the check word still fits.
  function automatic int rem_width(input int data_w, input int addr_w);
    return data_w - addr_w + 1;
  endfunction

  // crc_en sits directly after the channel address registers.
  function automatic int cfg_crc_addr(input int num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/yas_router_out_slot.sv
// yas_router_out_slot
// One output channel: a data register plus its valid flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture data_i and raise req_o this cycle
//   data_i       word to capture
//   ack_i        downstream accepts the held word when req_o && ack_i
//   data_o       held word
//   req_o        held word valid
//   ready_o      slot can take a new word this cycle
module yas_router_out_slot
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ack_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_o,
  output logic                  ready_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;

  // A word being acked this cycle frees the slot, so load and drain overlap.
  assign ready_o = ~req_q | ack_i;

  always_comb begin
    data_d = data_q;
    req_d  = req_q;
    if (load_i) begin
      data_d = data_i;
      req_d  = 1'b1;
    end else if (ack_i) begin
      req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      req_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      req_q  <= req_d;
    end
  end

  assign data_o = data_q;
  assign req_o  = req_q;

endmodule

// File: rtl/yas_router_core.sv
// yas_router_core
// Packet router: each packet's header selects every output channel whose
// address register equals the header dest field; the packet is copied to all
// of them in lock-step. Optional trailing XOR check word when crc_en is set.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_in/_req/_ack          input word stream
//   data_out/_req/_ack         NUM_CH output channels, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   config_addr/_data/_en      register file: 0..NUM_CH-1 channel addr, NUM_CH crc_en
//   pkt_drop                   one-cycle pulse after a header matching no channel
//   crc_err                    one-cycle pulse after a bad check word
// Optional feature: define YAS_ROUTER_BCAST_EN to make dest all-ones address
// every channel.
module yas_router_core
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_CH     = 3,
  parameter int CFG_AW     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         data_in_req,
  output logic                         data_in_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_out_req,
  input  logic [NUM_CH-1:0]            data_out_ack,
  input  logic [CFG_AW-1:0]            config_addr,
  input  logic [ADDR_WIDTH-1:0]        config_data,
  input  logic                         config_en,
  output logic                         pkt_drop,
  output logic                         crc_err
);

  localparam int LEN_LSB = hdr_len_lsb(ADDR_WIDTH);
  localparam int LEN_W   = hdr_len_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int REM_W   = rem_width(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [CFG_AW-1:0] CRC_ADDR = CFG_AW'(cfg_crc_addr(NUM_CH));

  // Config register file
  logic [ADDR_WIDTH-1:0] chaddr_q [NUM_CH];
  logic                  crc_en_q;

  // Packet state
  state_e                state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic                  crc_snap_q, crc_snap_d;
  logic                  pkt_drop_q, pkt_drop_d;
  logic                  crc_err_q, crc_err_d;

  logic [ADDR_WIDTH-1:0] hdr_dest;
  logic [LEN_W-1:0]      hdr_len;
  logic [NUM_CH-1:0]     addr_match;
  logic [NUM_CH-1:0]     hdr_mask;
  logic [NUM_CH-1:0]     ready;
  logic [NUM_CH-1:0]     load;

  assign hdr_dest = data_in[ADDR_WIDTH-1:0];
  assign hdr_len  = data_in[LEN_LSB +: LEN_W];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chaddr_q[gi] <= ADDR_WIDTH'(gi);
        end else if (config_en && (config_addr == CFG_AW'(gi))) begin
          chaddr_q[gi] <= config_data;
        end
      end

      assign addr_match[gi] = (hdr_dest == chaddr_q[gi]);

      yas_router_out_slot #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load[gi]),
        .data_i  (data_in),
        .ack_i   (data_out_ack[gi]),
        .data_o  (data_out[gi*DATA_WIDTH +: DATA_WIDTH]),
        .req_o   (data_out_req[gi]),
        .ready_o (ready[gi])
      );
    end
  endgenerate

`ifdef YAS_ROUTER_BCAST_EN
  assign hdr_mask = (&hdr_dest) ? {NUM_CH{1'b1}} : addr_match;
`else
  assign hdr_mask = addr_match;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_en_q <= 1'b0;
    end else if (config_en && (config_addr == CRC_ADDR)) begin
      crc_en_q <= config_data[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    xor_d       = xor_q;
    mask_d      = mask_q;
    crc_snap_d  = crc_snap_q;
    pkt_drop_d  = 1'b0;
    crc_err_d   = 1'b0;
    data_in_ack = 1'b0;
    load        = '0;

    case (state_q)
      S_IDLE: begin
        // An unmatched header is swallowed without waiting on any channel.
        data_in_ack = data_in_req && ((hdr_mask == '0) || (&(ready | ~hdr_mask)));
        if (data_in_ack) begin
          // Snapshot routing and check mode so mid-packet writes wait a packet.
          mask_d     = hdr_mask;
          crc_snap_d = crc_en_q;
          if (hdr_mask != '0) begin
            load  = hdr_mask;
            rem_d = REM_W'(hdr_len);
            xor_d = data_in;
            if (hdr_len != '0) begin
              state_d = S_FWD;
            end else if (crc_en_q) begin
              state_d = S_CHK;
            end
          end else begin
            pkt_drop_d = 1'b1;
            rem_d      = REM_W'(hdr_len) + REM_W'(crc_en_q);
            if (rem_d != '0) begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_FWD: begin
        data_in_ack = data_in_req && (&(ready | ~mask_q));
        if (data_in_ack) begin
          load  = mask_q;
          xor_d = xor_q ^ data_in;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = crc_snap_q ? S_CHK : S_IDLE;
          end
        end
      end
      S_CHK: begin
        data_in_ack = data_in_req && (&(ready | ~mask_q));
        if (data_in_ack) begin
          load      = mask_q;
          crc_err_d = (data_in != xor_q);
          state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        data_in_ack = data_in_req;
        if (data_in_ack) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      xor_q      <= '0;
      mask_q     <= '0;
      crc_snap_q <= 1'b0;
      pkt_drop_q <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      xor_q      <= xor_d;
      mask_q     <= mask_d;
      crc_snap_q <= crc_snap_d;
      pkt_drop_q <= pkt_drop_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign pkt_drop = pkt_drop_q;
  assign crc_err  = crc_err_q;

endmodule

// File: tb/tb_yas_router_core.sv
// tb_yas_router_core
// Table of packets with expected channel masks and pulse counts, driven
// through the router; a per-channel scoreboard queue holds expected words and
// is popped whenever a channel hands a word downstream. Hand-written
// sequences cover backpressure, a maximum-length drop, mid-packet config and
// mid-packet reset. Define YAS_ROUTER_BCAST_EN to match a broadcast build.
module tb_yas_router_core;
  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int NCH = 3;
  localparam int CAW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    data_in;
  logic             data_in_req;
  logic             data_in_ack;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]   data_out_req;
  logic [NCH-1:0]   data_out_ack;
  logic [CAW-1:0]   config_addr;
  logic [AW-1:0]    config_data;
  logic             config_en;
  logic             pkt_drop;
  logic             crc_err;

  always #5 clk = ~clk;

  yas_router_core #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CFG_AW(CAW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .data_in_req(data_in_req), .data_in_ack(data_in_ack),
    .data_out(data_out), .data_out_req(data_out_req), .data_out_ack(data_out_ack),
    .config_addr(config_addr), .config_data(config_data), .config_en(config_en),
    .pkt_drop(pkt_drop), .crc_err(crc_err)
  );

  int checks = 0;
  int errors = 0;
  int drop_seen = 0;
  int err_seen = 0;
  logic [DW-1:0] exp_q [NCH][$];

  typedef struct {
    logic           do_cfg;
    logic [CAW-1:0] ca;
    logic [AW-1:0]  cd;
    int             n;      // words in packet, 0 = config only
    logic [DW-1:0]  w [4];
    logic [NCH-1:0] mask;
    int             drops;
    int             errs;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic do_cfg, input logic [CAW-1:0] ca, input logic [AW-1:0] cd,
                              input int n, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                              input logic [NCH-1:0] mask, input int drops, input int errs);
    vec_t v;
    v.do_cfg = do_cfg; v.ca = ca; v.cd = cd; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.mask = mask; v.drops = drops; v.errs = errs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end else begin
      $display("check %s: %0h", name, got);
    end
  endtask

  task automatic monitor_loop();
    logic [DW-1:0] got;
    logic [DW-1:0] expw;
    forever begin
      @(negedge clk);
      if (pkt_drop) drop_seen++;
      if (crc_err)  err_seen++;
      for (int c = 0; c < NCH; c++) begin
        if (data_out_req[c] && data_out_ack[c]) begin
          got = data_out[c*DW +: DW];
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++;
            $display("FAIL ch%0d_word: got %02h expected no word", c, got);
          end else begin
            expw = exp_q[c].pop_front();
            if (got !== expw) begin
              errors++;
              $display("FAIL ch%0d_word: got %02h expected %02h", c, got, expw);
            end else begin
              $display("ch%0d word %02h", c, got);
            end
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, output int stalls);
    data_in     = w;
    data_in_req = 1'b1;
    stalls      = 0;
    forever begin
      @(negedge clk);
      if (data_in_ack) break;
      stalls++;
      if (stalls > 50) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: word %02h got no ack after %0d cycles, required ack", w, stalls);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [NCH-1:0] mask, input logic [DW-1:0] w);
    for (int c = 0; c < NCH; c++) if (mask[c]) exp_q[c].push_back(w);
  endtask

  task automatic cfg_write(input logic [CAW-1:0] a, input logic [AW-1:0] d);
    config_addr = a;
    config_data = d;
    config_en   = 1'b1;
    @(posedge clk); #1;
    config_en   = 1'b0;
    $display("cfg write addr %0d data %0d", a, d);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int st, s0, s1, d0, e0, tot;
    rst_n        = 1'b0;
    data_in      = '0;
    data_in_req  = 1'b0;
    data_out_ack = '1;
    config_addr  = '0;
    config_data  = '0;
    config_en    = 1'b0;

    vecs[0]  = mk(0, 0, 0, 3, 8'h09, 8'hA5, 8'h3C, 8'h00, 3'b010, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 0, 0);
    vecs[2]  = mk(1, 2, 1, 2, 8'h05, 8'h77, 8'h00, 8'h00, 3'b110, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0);
    vecs[4]  = mk(1, 2, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0);
    vecs[5]  = mk(0, 0, 0, 2, 8'h07, 8'h55, 8'h00, 8'h00, 3'b000, 1, 0);
`ifdef YAS_ROUTER_BCAST_EN
    vecs[6]  = mk(1, 5, 3, 1, 8'h03, 8'h00, 8'h00, 8'h00, 3'b111, 0, 0);
`else
    vecs[6]  = mk(1, 5, 3, 1, 8'h03, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0);
`endif
    vecs[7]  = mk(1, 3, 1, 3, 8'h04, 8'h11, 8'h15, 8'h00, 3'b111, 0, 0);
    vecs[8]  = mk(0, 0, 0, 3, 8'h04, 8'h11, 8'h16, 8'h00, 3'b111, 0, 1);
    vecs[9]  = mk(0, 0, 0, 4, 8'h09, 8'hA5, 8'h3C, 8'h99, 3'b000, 1, 0);
    vecs[10] = mk(1, 3, 0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0);
    vecs[11] = mk(1, 7, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b111, 0, 0);

    fork
      monitor_loop();
    join_none

    // Reset state
    idle_cycles(2);
    check("reset_data_out", 32'(data_out), 0);
    check("reset_data_out_req", 32'(data_out_req), 0);
    check("reset_pulses", {30'b0, pkt_drop, crc_err}, 0);
    rst_n = 1'b1;
    idle_cycles(2);
    check("idle_no_ack", 32'(data_in_ack), 0);

    // Table-driven packets
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_cfg) cfg_write(vecs[i].ca, vecs[i].cd);
      if (vecs[i].n > 0) begin
        d0 = drop_seen;
        e0 = err_seen;
        for (int k = 0; k < vecs[i].n; k++) push_exp(vecs[i].mask, vecs[i].w[k]);
        $display("vec %0d: header %02h, %0d words, mask %03b", i, vecs[i].w[0], vecs[i].n, vecs[i].mask);
        tot = 0;
        for (int k = 0; k < vecs[i].n; k++) begin
          send_word(vecs[i].w[k], st);
          tot += st;
        end
        data_in_req = 1'b0;
        idle_cycles(3);
        check($sformatf("vec%0d_stalls", i), 32'(tot), 0);
        check($sformatf("vec%0d_pkt_drop", i), 32'(drop_seen - d0), 32'(vecs[i].drops));
        check($sformatf("vec%0d_crc_err", i), 32'(err_seen - e0), 32'(vecs[i].errs));
      end
    end

    // Backpressure on a multicast channel: addresses 0,1,1, crc off
    cfg_write(1, 1);
    cfg_write(2, 1);
    push_exp(3'b110, 8'h05);
    push_exp(3'b110, 8'h77);
    data_out_ack[2] = 1'b0;
    fork
      begin
        send_word(8'h05, s0);
        send_word(8'h77, s1);
        data_in_req = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 data_out_ack[2] = 1'b1;
      end
    join
    idle_cycles(3);
    check("bp_header_stalls", 32'(s0), 0);
    check("bp_payload_stalls", 32'(s1), 3);

    // Longest dropped packet with check word: len 63 + 1
    cfg_write(3, 1);
    d0 = drop_seen;
    e0 = err_seen;
    send_word(8'hFE, st);
    tot = st;
    for (int k = 0; k < 64; k++) begin
      send_word(8'($urandom_range(0, 255)), st);
      tot += st;
    end
    push_exp(3'b001, 8'h00);
    push_exp(3'b001, 8'h00);
    send_word(8'h00, st);
    tot += st;
    send_word(8'h00, st);
    tot += st;
    data_in_req = 1'b0;
    idle_cycles(3);
    check("maxdrop_stalls", 32'(tot), 0);
    check("maxdrop_pkt_drop", 32'(drop_seen - d0), 1);
    check("maxdrop_crc_err", 32'(err_seen - e0), 0);
    cfg_write(3, 0);

    // Mid-packet address change uses the old mask
    cfg_write(2, 2);
    push_exp(3'b010, 8'h09);
    push_exp(3'b010, 8'hA5);
    push_exp(3'b010, 8'h3C);
    send_word(8'h09, st);
    send_word(8'hA5, st);
    data_in_req = 1'b0;
    cfg_write(1, 3);
    send_word(8'h3C, st);
    data_in_req = 1'b0;
    d0 = drop_seen;
    send_word(8'h05, st);
    send_word(8'h66, st);
    data_in_req = 1'b0;
    idle_cycles(3);
    check("midcfg_next_pkt_drop", 32'(drop_seen - d0), 1);

    // Reset mid-packet
    cfg_write(3, 1);
    push_exp(3'b100, 8'h0E);
    send_word(8'h0E, st);
    send_word(8'h11, st);
    data_in_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_data_out_req", 32'(data_out_req), 0);
    check("midrst_pulses", {30'b0, pkt_drop, crc_err}, 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    push_exp(3'b010, 8'h09);
    push_exp(3'b010, 8'hA5);
    push_exp(3'b010, 8'h3C);
    push_exp(3'b100, 8'h02);
    push_exp(3'b001, 8'h00);
    send_word(8'h09, st);
    send_word(8'hA5, st);
    send_word(8'h3C, st);
    send_word(8'h02, st);
    send_word(8'h00, st);
    data_in_req = 1'b0;
    idle_cycles(4);

    for (int c = 0; c < NCH; c++) check($sformatf("ch%0d_words_left", c), 32'(exp_q[c].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/yas_router_core.md
Name: yas_router_core

Overview:
- Parametrised packet router: accepts a word stream on one input handshake and forwards each packet to every output channel whose configured address matches the packet's destination field.
- Replaces the fixed 3-channel router datapath with NUM_CH channels, generic address width, multicast delivery, per-packet config snapshot and an optional trailing XOR check word.
- Sits under the router top level and contains its own config register file.

Parameters:
- DATA_WIDTH, 8: word width; header = {len[DATA_WIDTH-1:ADDR_WIDTH], dest[ADDR_WIDTH-1:0]}.
- ADDR_WIDTH, 2: destination and channel-address width; must be < DATA_WIDTH.
- NUM_CH, 3: number of output channels, 1..8.
- CFG_AW, 3: config address width; must satisfy 2^CFG_AW > NUM_CH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  input word.
- data_in_req  in  1  input word valid; held until acked.
- data_in_ack  out  1  word accepted when req&&ack in the same cycle.
- data_out  out  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- data_out_req  out  NUM_CH  per-channel word valid.
- data_out_ack  in  NUM_CH  per-channel transfer when req&&ack.
- config_addr  in  CFG_AW  0..NUM_CH-1 selects a channel address register; NUM_CH selects crc_en.
- config_data  in  ADDR_WIDTH  write data; crc_en takes bit 0.
- config_en  in  1  one-cycle write strobe.
- pkt_drop  out  1  one-cycle pulse when a header matches no channel.
- crc_err  out  1  one-cycle pulse when a check word mismatches.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: channel c address = c (mod 2^ADDR_WIDTH), crc_en = 0, FSM = IDLE; data_out, data_out_req, pkt_drop and crc_err all 0.
- Config writes:
  - Take effect the cycle after config_en.
  - Writes to addresses above NUM_CH are ignored.
  - The target mask and crc_en are snapshotted at header accept; mid-packet writes affect the next packet only.
- Output slots:
  - Each channel has one output register plus a valid flag (data_out_req).
  - ready[c] = ~data_out_req[c] | data_out_ack[c], so a fully acked channel sustains one word per cycle.
- FSM states: IDLE, FWD, CHK, DROP.
- IDLE (the current data_in is the header):
  - mask[c] = (dest == chaddr[c]).
  - data_in_ack = req && (mask == 0 || all ready[c] with mask[c]).
  - On accept with mask != 0: load the header into each masked slot and set its req; rem = len; xor_acc = header.
    - Next state FWD if len > 0, else CHK if crc_en, else IDLE.
  - On accept with mask == 0: pulse pkt_drop; rem = len + crc_en.
    - Next state DROP if rem > 0, else IDLE.
- FWD:
  - ack when all masked slots are ready.
  - On each accept: load the masked slots, xor_acc ^= word, rem--.
  - When rem reaches 0: go to CHK if crc_en, else IDLE.
- CHK:
  - Forward the word like FWD.
  - If word != xor_acc, pulse crc_err on the next cycle.
  - Go to IDLE.
- DROP: ack = req (no backpressure), rem--; IDLE when rem reaches 0.
- Multicast: all masked channels are loaded in the same cycle. A slow channel stalls the packet for all of them; there is no per-channel skew.
- Counter widths: rem is DATA_WIDTH-ADDR_WIDTH+1 bits. len = all-ones plus crc_en must not overflow.
- Reset mid-packet: everything clears immediately and any in-flight words are lost. After reset, the first accepted word is treated as a header.
- Output latency: one cycle from input accept to data_out_req.

Optional Feature:
- Macro: YAS_ROUTER_BCAST_EN.
- Defined: dest == all-ones forces mask = all channels, regardless of channel address registers.
- Undefined: all-ones is an ordinary address matched against the registers.

Decomposition:
- Shared package yas_router_pkg holds:
  - the FSM state encoding (2-bit localparams);
  - header field slice constants, derived from DATA_WIDTH and ADDR_WIDTH;
  - the config address for crc_en (= NUM_CH).
- Sub-module yas_router_out_slot is natural: one channel's register plus valid/ready, instantiated NUM_CH times via generate.

Test Plan:
- Defaults (NUM_CH=3, ADDR_WIDTH=2, addresses 0,1,2), header 8'h09 (dest 1, len 2) then 8'hA5, 8'h3C, all acks high -> channel 1 sees 09, A5, 3C on consecutive cycles; channels 0 and 2 idle.
- Write ch2 addr = 1, then send 8'h05 (dest 1, len 1), 8'h77 -> channels 1 and 2 both receive 05, 77. Hold data_out_ack[2] low 3 cycles -> data_in_ack low for those cycles; no words lost or duplicated.
- Write ch0..2 addresses = 0,0,0, send header 8'h07 (dest 3, len 1) plus one payload word -> pkt_drop pulses once, two words acked back-to-back, no data_out_req.
- crc_en = 1, send 8'h04, 8'h11, then check word 8'h15 -> no crc_err. Repeat with check word 8'h16 -> crc_err pulses once; all 3 words are still forwarded.
- Change ch1 address mid-packet, then assert rst_n low mid-packet -> the current packet uses the old mask. After reset, all outputs are 0 and the next accepted word is parsed as a header with default addresses.
- With YAS_ROUTER_BCAST_EN defined, header 8'h03 (dest 3, len 0) -> all 3 channels receive 03. With the macro undefined, the same header is dropped.
